div_seq_ctrl: RTL and testbench
===============================

// Module: div_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for divw/divwu: one radix-2 restoring-division step per cycle.
//  Lets the single-cycle ALU stay combinational.
//  Sits beside the ALU in EX; asserts busy so the hazard unit stalls IF/ID/EX.
//  Returns quotient, OV and CR0 on a one-cycle done pulse.
// PARAMETERS
//  WIDTH   32  operand/quotient width (big-endian bit order [0:WIDTH-1])
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      synchronous reset, active low
//  start      in   1      request; sampled only in IDLE or DONE
//  signed_op  in   1      1 = divw (signed), 0 = divwu
//  flush      in   1      pipeline flush; aborts any operation in flight
//  so_in      in   1      current XER[SO]
//  dividend   in   WIDTH  rA
//  divisor    in   WIDTH  rB
//  busy       out  1      operation in PREP/ITER/FIX
//  done       out  1      one-cycle result-valid pulse
//  quotient   out  WIDTH  result; held until next done
//  ov         out  1      overflow/undefined flag; held with quotient
//  cr0        out  4      {LT,GT,EQ,SO} of quotient; held with quotient
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//   - state=IDLE; busy=done=ov=0; quotient=0; cr0=0.
//   - Operation in flight is discarded; no done.
//  States: IDLE, PREP, ITER, FIX, DONE.
//   - IDLE -start-> PREP: latch operands, signed_op, so_in.
//   - PREP: on exception -> DONE; else -> ITER.
//     Signed: form |dividend|, |divisor|, record sign_q = sign(A)^sign(B), rem=0, cnt=0.
//   - ITER: rem = {rem,msb(dq)} - dvs if non-negative (q bit=1), else restore (q bit=0).
//     cnt++; after WIDTH steps -> FIX.
//   - FIX: negate quotient if sign_q; load quotient/ov/cr0 -> DONE.
//   - DONE: done=1 for this cycle only. start=1 -> PREP (back-to-back); else -> IDLE.
//   - Outputs: busy=1 in PREP/ITER/FIX only. start in PREP/ITER/FIX is ignored (not queued).
//  Latency (edge 0 = edge sampling start):
//   - normal: done high in the cycle after edge WIDTH+2 (34 for WIDTH=32).
//   - exception: done high in the cycle after edge 1.
//  Exceptions, detected in PREP:
//   - divisor==0 (both modes), or signed dividend==0x8000_0000 with divisor==0xFFFF_FFFF.
//   - Response: quotient=0, ov=1.
//  Results:
//   - Quotient truncates toward zero; remainder not output.
//   - ov=0 on every non-exception result.
//   - cr0: LT/GT/EQ from signed compare of final quotient vs 0; SO = latched so_in | ov.
//  flush:
//   - In PREP/ITER/FIX: next state IDLE, no done, outputs keep previous result.
//   - In DONE: done still asserts this cycle; the flush does not suppress it.
//   - flush and start together in IDLE/DONE: flush wins, stays/returns IDLE.
//  Priority: rst_n > flush > start.
//  Arithmetic: rem and divisor paths are WIDTH+1 bits so the compare sign is explicit.
//   - Unsigned mode never negates.
// TESTING
//  1. divwu 100/7, start at edge 0 -> done after edge 34; quotient=14, ov=0, cr0=4'b0100.
//  2. divw 0xFFFF_FF9C(-100)/7 -> quotient=0xFFFF_FFF2, ov=0, cr0=4'b1000; 0/5 -> cr0=4'b0010.
//  3. divisor=0 (both modes) and divw 0x8000_0000/0xFFFF_FFFF:
//     done after edge 1, quotient=0, ov=1, cr0 SO=1.
//  4. divwu 0x8000_0000/0xFFFF_FFFF -> quotient=0, ov=0 at latency 34;
//     divwu 0xFFFF_FFFF/1 -> 0xFFFF_FFFF.
//  5. flush at edge 10 -> busy low after edge 10, no done, prior quotient held;
//     start at edge 11 -> done after edge 45.
//  6. start pulsed at edge 5 mid-op -> ignored; start held in DONE -> back-to-back op;
//     rst_n=0 at edge 20 -> all outputs 0, no done.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Multi-cycle divw/divwu sequencer: one radix-2 restoring step per cycle,
// exposing busy for pipeline stall and a one-cycle done pulse with the result.
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic             so_in,
  input  logic [0:WIDTH-1] dividend,
  input  logic [0:WIDTH-1] divisor,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] quotient,
  output logic             ov,
  output logic [0:3]       cr0
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, dq;
  logic [WIDTH:0]   rem, dvs;
  logic [CNT_W-1:0] cnt;
  logic             signed_q, so_q, sign_q;

  logic             accept, exc, last_step;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix;
  logic [WIDTH:0]   shifted, diff;

  assign accept    = start && !flush && (state == S_IDLE || state == S_DONE);
  assign exc       = (b_q == '0) ||
                     (signed_q && a_q == {1'b1, {(WIDTH-1){1'b0}}} && b_q == '1);
  assign a_abs     = (signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs     = (signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
  // rem never exceeds the divisor magnitude, so its top bit is dropped before shifting
  assign shifted   = {rem[WIDTH-1:0], dq[WIDTH-1]};
  assign diff      = shifted - dvs;
  assign q_fix     = sign_q ? -dq : dq;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_PREP;
      S_PREP: begin
        busy = 1'b1;
        if (flush)    state_nxt = S_IDLE;
        else if (exc) state_nxt = S_DONE;
        else          state_nxt = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (flush)          state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = accept ? S_PREP : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      dq       <= '0;
      rem      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      signed_q <= 1'b0;
      so_q     <= 1'b0;
      sign_q   <= 1'b0;
      quotient <= '0;
      ov       <= 1'b0;
      cr0      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q      <= dividend;
            b_q      <= divisor;
            signed_q <= signed_op;
            so_q     <= so_in;
          end
        end
        S_PREP: begin
          if (!flush) begin
            if (exc) begin
              quotient <= '0;
              ov       <= 1'b1;
              cr0      <= 4'b0011;
            end else begin
              dq     <= a_abs;
              dvs    <= {1'b0, b_abs};
              rem    <= '0;
              cnt    <= '0;
              sign_q <= signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            end
          end
        end
        S_ITER: begin
          if (!diff[WIDTH]) rem <= diff;
          else              rem <= shifted;
          dq  <= {dq[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!flush) begin
            quotient <= q_fix;
            ov       <= 1'b0;
            cr0      <= {q_fix[WIDTH-1], !q_fix[WIDTH-1] && (q_fix != '0),
                         q_fix == '0, so_q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed spec cases plus randomized
// operations checked against a plain-arithmetic divide model.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, signed_op, flush, so_in;
  logic [0:31] dividend, divisor;
  logic        busy, done, ov;
  logic [0:31] quotient;
  logic [0:3]  cr0;

  int total = 0;
  int bad   = 0;

  div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .flush(flush), .so_in(so_in), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .ov(ov), .cr0(cr0)
  );

  always #5 clk = ~clk;

  // Reference: Power divw/divwu semantics in plain arithmetic.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic so, output logic [31:0] q, output logic o,
                         output logic [3:0] c, output int lat);
    logic signed [31:0] sa, sb, sq;
    sa = a; sb = b;
    if (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      q = 0; o = 1'b1; lat = 1;
    end else begin
      o = 1'b0; lat = 34;
      if (s) begin sq = sa / sb; q = sq; end
      else q = a / b;
    end
    sq = q;
    c = {sq < 0, sq > 0, q == 0, so | o};
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic so);
    dividend = a; divisor = b; signed_op = s; so_in = so; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns the number of edges until done is seen, 0 if never within limit.
  task automatic wait_done(input int limit, output int lat);
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; signed_op = 1'b0; so_in = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, ov, quotient, cr0} !== 39'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b ov=%b q=%h cr0=%b, want all 0",
               busy, done, ov, quotient, cr0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic so);
    logic [31:0] eq; logic eo; logic [3:0] ec; int elat, lat;
    ref_div(a, b, s, so, eq, eo, ec, elat);
    launch(a, b, s, so);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL %s_busy: got %b want 1", name, busy);
    end
    wait_done(60, lat);
    total++;
    if (lat != elat) begin
      bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, elat);
    end
    total++;
    if (quotient !== eq || ov !== eo || cr0 !== ec) begin
      bad++;
      $display("FAIL %s_result (%h/%h s=%b): got q=%h ov=%b cr0=%b want q=%h ov=%b cr0=%b",
               name, a, b, s, quotient, ov, cr0, eq, eo, ec);
    end
  endtask

  task automatic test_directed;
    run_check("divwu_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
    run_check("divw_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0);
    run_check("divw_0_5", 32'd0, 32'd5, 1'b1, 1'b0);
    run_check("divwu_by0", 32'd1234, 32'd0, 1'b0, 1'b0);
    run_check("divw_by0", 32'hFFFF_0000, 32'd0, 1'b1, 1'b0);
    run_check("divw_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_check("divwu_big", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_check("divwu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    run_check("divw_neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    logic [31:0] a, b; logic s;
    for (int n = 0; n < 24; n++) begin
      a = $urandom; b = $urandom; s = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: b = 0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: a = $urandom_range(0, 50);
        default: ;
      endcase
      run_check("random", a, b, s, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_flush;
    int lat;
    run_check("pre_flush", 32'd100, 32'd7, 1'b0, 1'b0);
    launch(32'd999, 32'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd14) begin
      bad++;
      $display("FAIL flush_abort: got busy=%b done=%b q=%h want busy=0 done=0 q=0000000e",
               busy, done, quotient);
    end
    run_check("after_flush", 32'd999, 32'd3, 1'b0, 1'b0);
    // flush together with start while DONE: done stays, then IDLE
    launch(32'd5, 32'd0, 1'b0, 1'b0);
    wait_done(5, lat);
    flush = 1'b1; start = 1'b1;
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL flush_in_done: got done=%b want 1", done);
    end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL flush_wins: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    launch(32'd1000, 32'd10, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd77; divisor = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60, lat);
    total++;
    if (lat != 29 || quotient !== 32'd100 || ov !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start: got lat=%0d q=%h ov=%b want lat=29 q=00000064 ov=0",
               lat, quotient, ov);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(32'd50, 32'd5, 1'b0, 1'b0);
    wait_done(60, lat);
    dividend = 32'hFFFF_FFF6; divisor = 32'd3; signed_op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL b2b_busy: got %b want 1", busy);
    end
    wait_done(60, lat);
    total++;
    if (lat != 34 || quotient !== 32'hFFFF_FFFD || cr0 !== 4'b1000) begin
      bad++;
      $display("FAIL b2b_result: got lat=%0d q=%h cr0=%b want lat=34 q=fffffffd cr0=1000",
               lat, quotient, cr0);
    end
  endtask

  task automatic test_reset_midop;
    int lat;
    launch(32'd12345, 32'd6, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if ({busy, done, ov, quotient, cr0} !== 39'd0) begin
      bad++;
      $display("FAIL reset_midop: got busy=%b done=%b ov=%b q=%h cr0=%b want all 0",
               busy, done, ov, quotient, cr0);
    end
    wait_done(40, lat);
    total++;
    if (lat != 0) begin
      bad++; $display("FAIL reset_no_done: got done at %0d want none", lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
